tpu_sequencer: RTL and testbench
================================

TPU_SEQUENCER -- requirements
Module: tpu_sequencer

Interface
REQ-001 Parameter IMEM_DEPTH, default 8: instruction memory entries; power of two.
REQ-002 Parameter COMPUTE_CYCLES, default 6: cycles valid is held per COMPUTE instruction; minimum 1.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to run the program from address 0.
REQ-006 prog_we  input  1  instruction memory write enable.
REQ-007 prog_addr  input  log2(IMEM_DEPTH)  instruction memory write address.
REQ-008 prog_data  input  16  instruction word: opcode [15:13], operand [12:0].
REQ-009 busy  output  1  high while a program is running.
REQ-010 done  output  1  high after END is reached; holds until the next start or reset.
REQ-011 err_illegal  output  1  high after an illegal opcode halts the run; holds until the next start or reset.
REQ-012 pc  output  log2(IMEM_DEPTH)  current instruction address.
REQ-013 base_address  output  13  address operand for weight memory and unified buffer.
REQ-014 load_weight, load_input, store  output  1 each  one-cycle command strobes.
REQ-015 valid  output  1  systolic array / accumulator compute enable.

Function
REQ-016 Opcodes SHALL be: 000 END, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUT, 100 COMPUTE, 101 STORE; 110 and 111 are illegal.
REQ-017 The FSM SHALL have states IDLE, FETCH, EXECUTE, COMPUTE and HALT.
REQ-018 IDLE: start=1 -> FETCH; in the same edge pc<=0, done<=0, err_illegal<=0.
REQ-019 FETCH SHALL register imem[pc] into an instruction register and go to EXECUTE (1 cycle).
REQ-020 EXECUTE, LOAD_ADDR: base_address<=operand; pc<=pc+1; go to FETCH.
REQ-021 EXECUTE, LOAD_WEIGHT, LOAD_INPUT or STORE: assert the matching strobe (registered) for exactly the single following cycle; pc<=pc+1; go to FETCH.
REQ-022 EXECUTE, COMPUTE: go to COMPUTE with counter cleared; valid SHALL be high for exactly COMPUTE_CYCLES consecutive cycles, starting the cycle after EXECUTE.
REQ-023 COMPUTE: on the last valid cycle, deassert valid at the next edge, set pc<=pc+1 and go to FETCH.
REQ-024 EXECUTE, END: go to HALT; done<=1.
REQ-025 EXECUTE, illegal opcode: go to HALT; err_illegal<=1; done stays 0; no strobe.
REQ-026 If pc=IMEM_DEPTH-1 and the instruction is not END, then after it completes: go to HALT, done<=1, pc does not wrap.
REQ-027 HALT: start=1 SHALL restart exactly as from IDLE; otherwise remain in HALT.
REQ-028 busy SHALL be high in FETCH, EXECUTE and COMPUTE, and low in IDLE and HALT.
REQ-029 start while busy SHALL be ignored.
REQ-030 prog_we while busy SHALL be ignored (memory unchanged); otherwise imem[prog_addr]<=prog_data on the edge.
REQ-031 At most one of load_weight, load_input, store and valid SHALL be high in any cycle.
REQ-032 base_address SHALL persist across runs until the next LOAD_ADDR or reset.
REQ-033 Operand bits of non-LOAD_ADDR instructions SHALL be ignored.

Reset
REQ-034 Reset SHALL take priority over all inputs in any state, including mid-COMPUTE.
REQ-035 Reset SHALL force state IDLE and pc=0, base_address=0, all strobes=0, valid=0, busy=0, done=0, err_illegal=0 on the next edge.
REQ-036 Reset SHALL NOT clear instruction memory contents.

Verification
REQ-037 Program {LOAD_ADDR 0x000F, LOAD_WEIGHT, LOAD_ADDR 0x001E, LOAD_INPUT, COMPUTE, LOAD_ADDR 0x0007, STORE, END}, then start -> strobes in order, each 1 cycle; base_address 0x000F/0x001E/0x0007 when respective strobes fire; valid high 6 cycles; done=1.
REQ-038 COMPUTE_CYCLES=1; program {COMPUTE, END} -> valid high exactly 1 cycle; then done.
REQ-039 imem[2]=16'hC000 (opcode 110) -> HALT with err_illegal=1, done=0, pc=2, no strobe.
REQ-040 Reset asserted on the 3rd valid cycle -> next edge: valid=0, busy=0, pc=0; memory intact; a new start reruns the program correctly.
REQ-041 All 8 entries LOAD_WEIGHT (no END) -> 8 strobes, then done=1 with pc=7; prog_we and start pulsed mid-run have no effect.

Source files
------------

// File: rtl/tpu_sequencer.sv
// Instruction sequencer for a small TPU datapath: runs a program held in a local
// instruction memory and issues load/compute/store command strobes.
module tpu_sequencer #(
  parameter int unsigned IMEM_DEPTH     = 8,
  parameter int unsigned COMPUTE_CYCLES = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [15:0]                   prog_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err_illegal,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [12:0]                   base_address,
  output logic                          load_weight,
  output logic                          load_input,
  output logic                          store,
  output logic                          valid
);

  localparam int unsigned AW    = $clog2(IMEM_DEPTH);
  localparam int unsigned IW    = 16;
  localparam int unsigned OPNDW = 13;
  localparam int unsigned CW    = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  localparam logic [AW-1:0] LAST_PC  = AW'(IMEM_DEPTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COMPUTE_CYCLES - 1);

  localparam logic [2:0] OP_END         = 3'b000;
  localparam logic [2:0] OP_LOAD_ADDR   = 3'b001;
  localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
  localparam logic [2:0] OP_LOAD_INPUT  = 3'b011;
  localparam logic [2:0] OP_COMPUTE     = 3'b100;
  localparam logic [2:0] OP_STORE       = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXECUTE = 3'd2,
    S_COMPUTE = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  state_e           state, state_n;
  logic [IW-1:0]    imem [IMEM_DEPTH];
  logic [IW-1:0]    ir, ir_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [AW-1:0]    pc_n;
  logic [OPNDW-1:0] base_n;
  logic             busy_n, done_n, err_n;
  logic             lw_n, li_n, st_n, valid_n;
  logic             advance;
  logic [2:0]       opcode;

  assign opcode = ir[15:13];

  // Program memory: host writes only while no program is running; not cleared by reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ir           <= '0;
      cnt          <= '0;
      pc           <= '0;
      base_address <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_illegal  <= 1'b0;
      load_weight  <= 1'b0;
      load_input   <= 1'b0;
      store        <= 1'b0;
      valid        <= 1'b0;
    end else begin
      state        <= state_n;
      ir           <= ir_n;
      cnt          <= cnt_n;
      pc           <= pc_n;
      base_address <= base_n;
      busy         <= busy_n;
      done         <= done_n;
      err_illegal  <= err_n;
      load_weight  <= lw_n;
      load_input   <= li_n;
      store        <= st_n;
      valid        <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    ir_n    = ir;
    cnt_n   = cnt;
    pc_n    = pc;
    base_n  = base_address;
    done_n  = done;
    err_n   = err_illegal;
    lw_n    = 1'b0;
    li_n    = 1'b0;
    st_n    = 1'b0;
    valid_n = 1'b0;
    advance = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
        end
      end
      S_FETCH: begin
        ir_n    = imem[pc];
        state_n = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (opcode)
          OP_END: begin
            state_n = S_HALT;
            done_n  = 1'b1;
          end
          OP_LOAD_ADDR: begin
            base_n  = ir[OPNDW-1:0];
            advance = 1'b1;
          end
          OP_LOAD_WEIGHT: begin
            lw_n    = 1'b1;
            advance = 1'b1;
          end
          OP_LOAD_INPUT: begin
            li_n    = 1'b1;
            advance = 1'b1;
          end
          OP_STORE: begin
            st_n    = 1'b1;
            advance = 1'b1;
          end
          OP_COMPUTE: begin
            state_n = S_COMPUTE;
            cnt_n   = '0;
            valid_n = 1'b1;
          end
          default: begin
            state_n = S_HALT;
            err_n   = 1'b1;
          end
        endcase
      end
      S_COMPUTE: begin
        if (cnt == CNT_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_n   = cnt + CW'(1);
          valid_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Completing the instruction in the last slot ends the run instead of wrapping pc.
    if (advance) begin
      if (pc == LAST_PC) begin
        state_n = S_HALT;
        done_n  = 1'b1;
      end else begin
        state_n = S_FETCH;
        pc_n    = pc + AW'(1);
      end
    end

    busy_n = (state_n == S_FETCH) || (state_n == S_EXECUTE) || (state_n == S_COMPUTE);
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: instruction-level reference model expanded into a
// per-cycle expected trace, checked every cycle, plus directed literal checks.
module tb_tpu_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned CC    = 6;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] pc;
    logic [12:0]   base;
    logic          lw;
    logic          li;
    logic          st;
    logic          valid;
  } obs_t;

  typedef struct packed {
    logic [1:0]  k;
    logic [12:0] b;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset, start, prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          busy, done, err_illegal, load_weight, load_input, store, valid;
  logic [AW-1:0] pc;
  logic [12:0]   base_address;
  logic          busy1, done1, err1, lw1, li1, st1, valid1;
  logic [AW-1:0] pc1;
  logic [12:0]   base1;

  obs_t        exp_q[$];
  obs_t        hold;
  ev_t         ev_q[$];
  logic [15:0] m_mem [DEPTH];
  logic [12:0] m_base;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  int          vcnt = 0;
  int          v1cnt = 0;

  always #5 clk = ~clk;

  tpu_sequencer #(.IMEM_DEPTH(DEPTH), .COMPUTE_CYCLES(CC)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy), .done(done),
    .err_illegal(err_illegal), .pc(pc), .base_address(base_address),
    .load_weight(load_weight), .load_input(load_input), .store(store), .valid(valid)
  );

  tpu_sequencer #(.IMEM_DEPTH(DEPTH), .COMPUTE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy1), .done(done1),
    .err_illegal(err1), .pc(pc1), .base_address(base1),
    .load_weight(lw1), .load_input(li1), .store(st1), .valid(valid1)
  );

  // Per-cycle comparison of the main DUT against the expected trace.
  always @(negedge clk) begin : cmp
    obs_t e;
    obs_t a;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        hold = e;
        hold.lw = 1'b0; hold.li = 1'b0; hold.st = 1'b0; hold.valid = 1'b0;
      end else begin
        e = hold;
      end
      a = {busy, done, err_illegal, pc, base_address, load_weight, load_input, store, valid};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace @%0t: got busy=%b done=%b err=%b pc=%0d base=%h lw/li/st/v=%b%b%b%b want busy=%b done=%b err=%b pc=%0d base=%h lw/li/st/v=%b%b%b%b",
                 $time, a.busy, a.done, a.err, a.pc, a.base, a.lw, a.li, a.st, a.valid,
                 e.busy, e.done, e.err, e.pc, e.base, e.lw, e.li, e.st, e.valid);
      end
      if (valid)  vcnt++;
      if (valid1) v1cnt++;
      if (load_weight) ev_q.push_back({2'd1, base_address});
      if (load_input)  ev_q.push_back({2'd2, base_address});
      if (store)       ev_q.push_back({2'd3, base_address});
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    m_mem[a]  = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_base = '0;
    hold   = '0;
    chk_en = 1'b1;
  endtask

  // Instruction-level model: each instruction is a fetch cycle and an execute
  // cycle, COMPUTE adds CC valid cycles, a strobe shows up one cycle after execute.
  task automatic run_model();
    int         p = 0;
    logic [2:0] pend = 3'b000;
    bit         halt = 1'b0;
    bit         fin_done = 1'b0;
    bit         fin_err = 1'b0;
    obs_t       o;
    logic [2:0] op;
    while (!halt) begin
      o = '0; o.busy = 1'b1; o.pc = AW'(p); o.base = m_base;
      {o.lw, o.li, o.st} = pend;
      pend = 3'b000;
      exp_q.push_back(o);
      o.lw = 1'b0; o.li = 1'b0; o.st = 1'b0;
      exp_q.push_back(o);
      op = m_mem[p][15:13];
      case (op)
        3'd0: begin halt = 1'b1; fin_done = 1'b1; end
        3'd1: m_base = m_mem[p][12:0];
        3'd2: pend = 3'b100;
        3'd3: pend = 3'b010;
        3'd5: pend = 3'b001;
        3'd4: begin o.valid = 1'b1; repeat (CC) exp_q.push_back(o); end
        default: begin halt = 1'b1; fin_err = 1'b1; end
      endcase
      if (!halt) begin
        if (p == DEPTH - 1) begin halt = 1'b1; fin_done = 1'b1; end
        else p++;
      end
    end
    o = '0; o.pc = AW'(p); o.base = m_base; o.done = fin_done; o.err = fin_err;
    {o.lw, o.li, o.st} = pend;
    exp_q.push_back(o);
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_model();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending cycles want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_events(input string name, input ev_t want[$]);
    chk({name, "_count"}, ev_q.size(), want.size());
    for (int i = 0; i < want.size() && i < ev_q.size(); i++)
      chk($sformatf("%s_ev%0d", name, i), 32'(ev_q[i]), 32'(want[i]));
  endtask

  function automatic logic [15:0] rand_instr();
    int unsigned r = $urandom_range(0, 19);
    logic [2:0]  op;
    if (r == 0)      op = 3'd0;
    else if (r == 1) op = 3'($urandom_range(6, 7));
    else             op = 3'($urandom_range(1, 5));
    return {op, 13'($urandom)};
  endfunction

  initial begin
    ev_t want[$];
    int  kill;
    int  nv;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick();
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", pc, 0);
    chk("rst_base", base_address, 0);
    for (int a = 0; a < DEPTH; a++) wr(a, 16'h0000);

    // Single-cycle compute on the COMPUTE_CYCLES=1 instance.
    wr(0, 16'h8000);
    wr(1, 16'h0000);
    vcnt = 0; v1cnt = 0;
    go();
    wait_done();
    chk("c1_valid_cycles", v1cnt, 1);
    chk("c1_done", done1, 1);
    chk("c6_valid_cycles", vcnt, 6);

    // Reference program.
    wr(0, 16'h200F); wr(1, 16'h4000); wr(2, 16'h201E); wr(3, 16'h6000);
    wr(4, 16'h8000); wr(5, 16'h2007); wr(6, 16'hA000); wr(7, 16'h0000);
    want = '{'{2'd1, 13'h000F}, '{2'd2, 13'h001E}, '{2'd3, 13'h0007}};
    ev_q.delete(); vcnt = 0;
    go();
    wait_done();
    chk_events("prog", want);
    chk("prog_valid_cycles", vcnt, 6);
    chk("prog_done", done, 1);
    chk("prog_base", base_address, 13'h0007);

    // Reset on the third valid cycle, then rerun.
    go();
    nv = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() > 0 && exp_q[0].valid) nv++;
      if (nv == 3) break;
      tick();
    end
    do_reset();
    chk("midrst_valid", valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pc", pc, 0);
    ev_q.delete(); vcnt = 0;
    go();
    wait_done();
    chk_events("rerun", want);
    chk("rerun_valid_cycles", vcnt, 6);
    chk("rerun_done", done, 1);

    // Illegal opcode halts at its own address.
    wr(0, 16'h2005); wr(1, 16'h4000); wr(2, 16'hC000);
    ev_q.delete();
    go();
    wait_done();
    chk("ill_err", err_illegal, 1);
    chk("ill_done", done, 0);
    chk("ill_pc", pc, 2);
    chk("ill_strobes", ev_q.size(), 1);

    // No END: run falls off the last slot; mid-run writes and start are ignored.
    for (int a = 0; a < DEPTH; a++) wr(a, 16'h4000);
    ev_q.delete();
    go();
    tick(); tick(); tick();
    prog_we = 1'b1; prog_addr = AW'(3); prog_data = 16'h0000; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    wait_done();
    chk("noend_strobes", ev_q.size(), 8);
    chk("noend_done", done, 1);
    chk("noend_pc", pc, 7);
    ev_q.delete();
    go();
    wait_done();
    chk("noend_mem_kept", ev_q.size(), 8);

    // Randomized programs with occasional mid-run resets and ignored host activity.
    for (int r = 0; r < 40; r++) begin
      for (int a = 0; a < DEPTH; a++)
        if ($urandom_range(0, 2) != 0) wr(a, rand_instr());
      go();
      kill = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 30)) : 0;
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
        if (kill != 0 && i == kill) begin
          do_reset();
          break;
        end
        if (exp_q.size() > 0 && exp_q[0].busy && $urandom_range(0, 5) == 0) begin
          start     = 1'($urandom_range(0, 1));
          prog_we   = 1'b1;
          prog_addr = AW'($urandom_range(0, DEPTH - 1));
          prog_data = 16'($urandom);
        end
        tick();
        start = 1'b0;
        prog_we = 1'b0;
      end
      wait_done();
    end

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
